morse_key_decoder: RTL

- Receive-side counterpart to the tick generators: measures key-down and key-up durations in time units and turns them into Morse symbols and assembled letters.
- Each time unit is one TICK pulse from a divide-by-N counter.
- Sits between the debounced key input and the letter lookup stage.
- Emits per-element symbols (dot, dash, letter gap, word gap) and one packed letter code per character.

---
 rtl/morse_key_decoder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/morse_key_decoder.sv
// Morse receive decoder: times key-down/key-up runs in TICK units and emits
// per-element symbols plus one packed letter code per character.
module morse_key_decoder #(
    parameter int CW         = 4,
    parameter int DASH_MIN   = 2,
    parameter int LETTER_GAP = 2,
    parameter int WORD_GAP   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       key,
    output logic       sym_valid,
    output logic [1:0] sym_code,
    output logic       letter_valid,
    output logic [5:0] letter_bits,
    output logic [2:0] letter_len,
    output logic       letter_err
);

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        SPACE
    } state_t;

    localparam logic [CW-1:0] CNT_MAX      = '1;
    localparam logic [CW-1:0] DASH_MIN_C   = CW'(DASH_MIN);
    localparam logic [CW-1:0] LETTER_GAP_C = CW'(LETTER_GAP);
    localparam logic [CW-1:0] WORD_GAP_C   = CW'(WORD_GAP);

    localparam logic [1:0] SYM_DOT    = 2'd0;
    localparam logic [1:0] SYM_DASH   = 2'd1;
    localparam logic [1:0] SYM_LETTER = 2'd2;
    localparam logic [1:0] SYM_WORD   = 2'd3;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [5:0]    bits;
    logic [2:0]    len;
    logic          err;

    logic [CW-1:0] cnt_inc;
    logic          in_letter;
    logic          is_dash;

    // Saturate so an over-long mark cannot wrap back to a zero-length glitch.
    assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    assign in_letter = (len != 3'd0) || err;
    assign is_dash   = (cnt >= DASH_MIN_C);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            bits         <= '0;
            len          <= '0;
            err          <= 1'b0;
            sym_valid    <= 1'b0;
            sym_code     <= '0;
            letter_valid <= 1'b0;
            letter_bits  <= '0;
            letter_len   <= '0;
            letter_err   <= 1'b0;
        end else begin
            // NOTE: pulses default low here; a later non-blocking assignment in
            // the same block overrides this, so each pulse lasts exactly one cycle.
            sym_valid    <= 1'b0;
            letter_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (key) begin
                        state <= MARK;
                        cnt   <= '0;
                    end
                end

                MARK: begin
                    if (!key) begin
                        cnt <= '0;
                        if (cnt == '0) begin
                            state <= in_letter ? SPACE : IDLE;
                        end else begin
                            state     <= SPACE;
                            sym_valid <= 1'b1;
                            sym_code  <= is_dash ? SYM_DASH : SYM_DOT;
                            if (len == 3'd6) begin
                                err <= 1'b1;
                            end else begin
                                bits <= {bits[4:0], is_dash};
                                len  <= len + 3'd1;
                            end
                        end
                    end else if (tick) begin
                        cnt <= cnt_inc;
                    end
                end

                SPACE: begin
                    // A key rise takes priority; the coincident tick is dropped.
                    if (key) begin
                        state <= MARK;
                        cnt   <= '0;
                    end else if (tick) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == LETTER_GAP_C && in_letter) begin
                            letter_valid <= 1'b1;
                            letter_bits  <= bits;
                            letter_len   <= len;
                            letter_err   <= err;
                            sym_valid    <= 1'b1;
                            sym_code     <= SYM_LETTER;
                            bits         <= '0;
                            len          <= '0;
                            err          <= 1'b0;
                        end
                        if (cnt_inc == WORD_GAP_C) begin
                            sym_valid <= 1'b1;
                            sym_code  <= SYM_WORD;
                            state     <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
